// File: rtl/accounter_pkg.sv
// Shared types and helpers for the multi-port write accounter.
package accounter_pkg;

  typedef enum logic [1:0] {
    COLL_LOW  = 2'd0,
    COLL_HIGH = 2'd1,
    COLL_RR   = 2'd2
  } coll_policy_t;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

  function automatic int idx_width(input int n);
    return (n == 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/collision_arbiter.sv
// Per-row combinational arbiter: picks the winning write agent among all
// agents targeting this row, according to the selected collision policy.
module collision_arbiter
  import accounter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  match,
  input  logic [IW-1:0] rr_ptr,
  input  coll_policy_t  policy,
  output logic          any,
  output logic          multi,
  output logic [IW-1:0] winner
);

  int   idx;
  logic found;

  assign any   = |match;
  // Clearing the lowest set bit leaves something only when two or more are set.
  assign multi = (match & (match - N'(1))) != '0;

  always_comb begin
    winner = '0;
    idx    = 0;
    found  = 1'b0;
    case (policy)
      COLL_HIGH: begin
        for (int i = 0; i < N; i++)
          if (match[i]) winner = IW'(i);
      end
      COLL_RR: begin
        for (int k = 0; k < N; k++) begin
          idx = (int'(rr_ptr) + k) % N;
          if (!found && match[idx]) begin
            winner = IW'(idx);
            found  = 1'b1;
          end
        end
      end
      default: begin
        for (int i = N - 1; i >= 0; i--)
          if (match[i]) winner = IW'(i);
      end
    endcase
  end

endmodule

// File: rtl/accounter_mp.sv
// Multi-port write accounter: tracks last writer / collision / written state
// per row and serves registered bank selects to NB_RDAGENT read ports.
module accounter_mp
  import accounter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 3,
  parameter int RAM_DEPTH       = 2**ADDR_WIDTH,
  parameter int NB_WRAGENT      = 2,
  parameter int NB_RDAGENT      = 2,
  parameter int WRITE_COLLISION = 1,
  parameter int COLL_POLICY     = 0,
  parameter int CNT_WIDTH       = 16,
  parameter int IDX_WIDTH       = idx_width(NB_WRAGENT),
  parameter int SELECT_WIDTH    = IDX_WIDTH + WRITE_COLLISION
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [NB_WRAGENT-1:0]              wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   wraddr,
  input  logic [NB_RDAGENT-1:0]              rden,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   rdaddr,
  output logic [NB_RDAGENT-1:0]              rdvalid,
  output logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select,
  output logic [NB_RDAGENT-1:0]              rdwritten,
  input  logic                               clr_req,
  output logic                               clr_busy,
  output logic                               coll_pulse,
  output logic [CNT_WIDTH-1:0]               coll_count
);

  localparam coll_policy_t POLICY = (COLL_POLICY == 2) ? COLL_RR :
                                    (COLL_POLICY == 1) ? COLL_HIGH : COLL_LOW;

  logic [RAM_DEPTH-1:0][NB_WRAGENT-1:0] match;
  logic [RAM_DEPTH-1:0]                 row_any, row_multi;
  logic [RAM_DEPTH-1:0][IDX_WIDTH-1:0]  row_win;

  logic [RAM_DEPTH-1:0][IDX_WIDTH-1:0]  cidx_q, cidx_d;
  logic [RAM_DEPTH-1:0]                 cflag_q, cflag_d, cwr_q, cwr_d;

  clr_state_t                           clr_state_q, clr_state_d;
  logic [ADDR_WIDTH-1:0]                sweep_q, sweep_d;
  logic [IDX_WIDTH-1:0]                 rr_q, rr_d;
  logic                                 coll_pulse_q, coll_pulse_d;
  logic [CNT_WIDTH-1:0]                 coll_count_q, coll_count_d;

  logic [NB_RDAGENT-1:0]                rdvalid_q, rdvalid_d, rdwritten_q, rdwritten_d;
  logic [NB_RDAGENT-1:0][SELECT_WIDTH-1:0] sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]                ra;

  logic busy, coll_cycle;

  for (genvar r = 0; r < RAM_DEPTH; r++) begin : g_row
    for (genvar i = 0; i < NB_WRAGENT; i++) begin : g_match
      assign match[r][i] = wren[i] && (wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r));
    end
    collision_arbiter #(.N(NB_WRAGENT), .IW(IDX_WIDTH)) u_arb (
      .match  (match[r]),
      .rr_ptr (rr_q),
      .policy (POLICY),
      .any    (row_any[r]),
      .multi  (row_multi[r]),
      .winner (row_win[r])
    );
  end

  assign busy       = (clr_state_q == CLR_SWEEP);
  // Writes during a sweep are dropped entirely, collisions included.
  assign coll_cycle = !busy && (|row_multi);

  always_comb begin
    cidx_d  = cidx_q;
    cflag_d = cflag_q;
    cwr_d   = cwr_q;
    if (busy) begin
      cidx_d[sweep_q]  = '0;
      cflag_d[sweep_q] = 1'b0;
      cwr_d[sweep_q]   = 1'b0;
    end else begin
      for (int r = 0; r < RAM_DEPTH; r++) begin
        if (row_any[r]) begin
          cidx_d[r]  = row_win[r];
          cflag_d[r] = row_multi[r];
          cwr_d[r]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    clr_state_d = clr_state_q;
    sweep_d     = sweep_q;
    if (busy) begin
      sweep_d = sweep_q + ADDR_WIDTH'(1);
      if (int'(sweep_q) == RAM_DEPTH - 1) clr_state_d = CLR_IDLE;
    end else if (clr_req) begin
      clr_state_d = CLR_SWEEP;
      sweep_d     = '0;
    end
  end

  always_comb begin
    coll_pulse_d = coll_cycle;
    coll_count_d = coll_count_q;
    rr_d         = rr_q;
    if (coll_cycle && !(&coll_count_q)) coll_count_d = coll_count_q + CNT_WIDTH'(1);
    if (coll_cycle && POLICY == COLL_RR)
      rr_d = (rr_q == IDX_WIDTH'(NB_WRAGENT - 1)) ? '0 : rr_q + IDX_WIDTH'(1);
  end

  // Reads see pre-write cell state; unrequested ports hold their last response.
  always_comb begin
    rdvalid_d   = rden;
    rdwritten_d = rdwritten_q;
    sel_d       = sel_q;
    ra          = '0;
    for (int p = 0; p < NB_RDAGENT; p++) begin
      if (rden[p]) begin
        ra = rdaddr[p*ADDR_WIDTH +: ADDR_WIDTH];
        if (int'(ra) < RAM_DEPTH) begin
          sel_d[p]       = SELECT_WIDTH'({cflag_q[ra], cidx_q[ra]});
          rdwritten_d[p] = cwr_q[ra];
        end else begin
          sel_d[p]       = '0;
          rdwritten_d[p] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cidx_q       <= '0;
      cflag_q      <= '0;
      cwr_q        <= '0;
      clr_state_q  <= CLR_IDLE;
      sweep_q      <= '0;
      rr_q         <= '0;
      coll_pulse_q <= 1'b0;
      coll_count_q <= '0;
      rdvalid_q    <= '0;
      rdwritten_q  <= '0;
      sel_q        <= '0;
    end else begin
      cidx_q       <= cidx_d;
      cflag_q      <= cflag_d;
      cwr_q        <= cwr_d;
      clr_state_q  <= clr_state_d;
      sweep_q      <= sweep_d;
      rr_q         <= rr_d;
      coll_pulse_q <= coll_pulse_d;
      coll_count_q <= coll_count_d;
      rdvalid_q    <= rdvalid_d;
      rdwritten_q  <= rdwritten_d;
      sel_q        <= sel_d;
    end
  end

  assign rdvalid     = rdvalid_q;
  assign rdwritten   = rdwritten_q;
  assign bank_select = sel_q;
  assign clr_busy    = busy;
  assign coll_pulse  = coll_pulse_q;
  assign coll_count  = coll_count_q;

endmodule

// File: tb/tb_accounter_mp.sv
// Randomized + directed bench: three DUTs (low/high/round-robin policy) share
// stimulus and are compared every cycle against a row-level reference model.
module tb_accounter_mp;
  localparam int AW = 3, DEPTH = 8, NW = 4, NR = 2, IW = 2, SW = 3, CW = 16;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NW-1:0]     wren;
  logic [NW*AW-1:0]  wraddr;
  logic [NR-1:0]     rden;
  logic [NR*AW-1:0]  rdaddr;
  logic              clr_req;

  logic [NR-1:0]     rdvalid     [3];
  logic [NR*SW-1:0]  bank_select [3];
  logic [NR-1:0]     rdwritten   [3];
  logic              clr_busy    [3];
  logic              coll_pulse  [3];
  logic [CW-1:0]     coll_count  [3];

  always #5 aclk = ~aclk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    accounter_mp #(
      .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .NB_WRAGENT(NW), .NB_RDAGENT(NR),
      .WRITE_COLLISION(1), .COLL_POLICY(k), .CNT_WIDTH(CW)
    ) u_dut (
      .aclk(aclk), .aresetn(aresetn), .wren(wren), .wraddr(wraddr),
      .rden(rden), .rdaddr(rdaddr), .rdvalid(rdvalid[k]),
      .bank_select(bank_select[k]), .rdwritten(rdwritten[k]),
      .clr_req(clr_req), .clr_busy(clr_busy[k]),
      .coll_pulse(coll_pulse[k]), .coll_count(coll_count[k])
    );
  end

  // reference model state, one copy per policy instance
  int m_own [3][DEPTH];
  int m_flag[3][DEPTH];
  int m_wr  [3][DEPTH];
  int m_rr  [3];
  int m_cnt [3];
  int m_sel [3][NR];
  int m_rdw [3][NR];
  int m_vld [NR];
  int m_pulse;
  int m_busy, m_sw;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void mdl_reset();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < DEPTH; r++) begin m_own[k][r] = 0; m_flag[k][r] = 0; m_wr[k][r] = 0; end
      for (int p = 0; p < NR; p++) begin m_sel[k][p] = 0; m_rdw[k][p] = 0; end
      m_rr[k] = 0; m_cnt[k] = 0;
    end
    for (int p = 0; p < NR; p++) m_vld[p] = 0;
    m_pulse = 0; m_busy = 0; m_sw = 0;
  endfunction

  function automatic void mdl_step();
    int a, w, best, d, coll;
    int lst[$];
    for (int p = 0; p < NR; p++) begin
      m_vld[p] = int'(rden[p]);
      if (rden[p]) begin
        a = int'(rdaddr[p*AW +: AW]);
        for (int k = 0; k < 3; k++) begin
          if (a < DEPTH) begin
            m_sel[k][p] = m_flag[k][a] * (1 << IW) + m_own[k][a];
            m_rdw[k][p] = m_wr[k][a];
          end else begin
            m_sel[k][p] = 0; m_rdw[k][p] = 0;
          end
        end
      end
    end
    if (m_busy != 0) begin
      for (int k = 0; k < 3; k++) begin
        m_own[k][m_sw] = 0; m_flag[k][m_sw] = 0; m_wr[k][m_sw] = 0;
      end
      m_pulse = 0;
      m_sw++;
      if (m_sw == DEPTH) m_busy = 0;
    end else begin
      coll = 0;
      for (int r = 0; r < DEPTH; r++) begin
        lst.delete();
        for (int i = 0; i < NW; i++)
          if (wren[i] && int'(wraddr[i*AW +: AW]) == r) lst.push_back(i);
        if (lst.size() == 1) begin
          for (int k = 0; k < 3; k++) begin m_own[k][r] = lst[0]; m_flag[k][r] = 0; m_wr[k][r] = 1; end
        end else if (lst.size() > 1) begin
          coll = 1;
          for (int k = 0; k < 3; k++) begin
            if (k == 0) w = lst[0];
            else if (k == 1) w = lst[lst.size()-1];
            else begin
              // nearest requester at or after the pointer, going round the ring
              best = NW; w = 0;
              foreach (lst[j]) begin
                d = (lst[j] - m_rr[k] + NW) % NW;
                if (d < best) begin best = d; w = lst[j]; end
              end
            end
            m_own[k][r] = w; m_flag[k][r] = 1; m_wr[k][r] = 1;
          end
        end
      end
      m_pulse = coll;
      if (coll != 0) begin
        for (int k = 0; k < 3; k++) begin
          if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
          if (k == 2) m_rr[k] = (m_rr[k] + 1) % NW;
        end
      end
      if (clr_req) begin m_busy = 1; m_sw = 0; end
    end
  endfunction

  task automatic cmp_all();
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < NR; p++) begin
        chk($sformatf("k%0d_p%0d_vld", k, p), 32'(rdvalid[k][p]), 32'(m_vld[p]));
        chk($sformatf("k%0d_p%0d_sel", k, p), 32'(bank_select[k][p*SW +: SW]), 32'(m_sel[k][p]));
        chk($sformatf("k%0d_p%0d_wr", k, p), 32'(rdwritten[k][p]), 32'(m_rdw[k][p]));
      end
      chk($sformatf("k%0d_pulse", k), 32'(coll_pulse[k]), 32'(m_pulse));
      chk($sformatf("k%0d_count", k), 32'(coll_count[k]), 32'(m_cnt[k]));
      chk($sformatf("k%0d_busy", k), 32'(clr_busy[k]), 32'(m_busy));
    end
  endtask

  task automatic cycle();
    mdl_step();
    @(posedge aclk);
    #1;
    cmp_all();
  endtask

  task automatic idle();
    wren = '0; wraddr = '0; rden = '0; rdaddr = '0; clr_req = 1'b0;
  endtask

  task automatic wr(input int ag, input int row);
    wren[ag] = 1'b1;
    wraddr[ag*AW +: AW] = AW'(row);
  endtask

  task automatic rd(input int p, input int row);
    rden[p] = 1'b1;
    rdaddr[p*AW +: AW] = AW'(row);
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_vld"},   32'(rdvalid[k]), 0);
      chk({tag, "_sel"},   32'(bank_select[k]), 0);
      chk({tag, "_wr"},    32'(rdwritten[k]), 0);
      chk({tag, "_busy"},  32'(clr_busy[k]), 0);
      chk({tag, "_pulse"}, 32'(coll_pulse[k]), 0);
      chk({tag, "_count"}, 32'(coll_count[k]), 0);
    end
  endtask

  task automatic do_reset();
    idle();
    aresetn = 1'b0;
    #1;
    chk_zero("reset");
    mdl_reset();
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic sweep_len(input string tag);
    int n = 0;
    idle(); clr_req = 1'b1; cycle(); idle();
    if (clr_busy[0]) n++;
    for (int c = 0; c < 11; c++) begin cycle(); if (clr_busy[0]) n++; end
    chk(tag, n, 8);
  endtask

  initial begin
    idle();
    aresetn = 1'b1;
    #2;
    do_reset();

    // single writer
    wr(2, 5); cycle(); idle();
    rd(0, 5); cycle(); idle();
    chk("single_sel", 32'(bank_select[0][2:0]), 32'b010);
    chk("single_wr", 32'(rdwritten[0][0]), 1);
    chk("single_vld", 32'(rdvalid[0][0]), 1);

    // low/high policy collision
    wr(1, 2); wr(3, 2); cycle(); idle();
    chk("coll_pulse", 32'(coll_pulse[0]), 1);
    chk("coll_count", 32'(coll_count[0]), 1);
    rd(0, 2); cycle(); idle();
    chk("coll_pulse_drop", 32'(coll_pulse[0]), 0);
    chk("coll_low_sel", 32'(bank_select[0][2:0]), 32'b101);
    chk("coll_high_sel", 32'(bank_select[1][2:0]), 32'b111);

    // round-robin: three collision cycles on row 4
    do_reset();
    wr(0, 4); wr(2, 4); cycle();
    rd(0, 4); cycle();
    chk("rr_win0", 32'(bank_select[2][2:0]), 32'b100);
    cycle(); idle();
    chk("rr_win1", 32'(bank_select[2][2:0]), 32'b110);
    rd(0, 4); cycle(); idle();
    chk("rr_win2", 32'(bank_select[2][2:0]), 32'b110);
    chk("rr_count", 32'(coll_count[2]), 3);

    // same-cycle read/write is not bypassed
    wr(0, 6); cycle(); idle();
    wr(1, 6); rd(1, 6); cycle(); idle();
    chk("rw_old", 32'(bank_select[0][5:3]), 32'b000);
    rd(1, 6); cycle(); idle();
    chk("rw_new", 32'(bank_select[0][5:3]), 32'b001);

    // clear sweep with dropped writes and an ignored clr_req
    for (int r = 0; r < DEPTH; r++) begin wr(r % NW, r); cycle(); idle(); end
    clr_req = 1'b1; cycle(); idle();
    cycle();
    for (int c = 0; c < 3; c++) begin wr(0, 3); wr(1, 3); clr_req = 1'b1; cycle(); idle(); end
    for (int c = 0; c < 6; c++) cycle();
    chk("clr_done", 32'(clr_busy[0]), 0);
    for (int r = 0; r < DEPTH; r++) begin
      rd(0, r); rd(1, r); cycle(); idle();
      chk($sformatf("clr_row%0d", r), 32'(rdwritten[0]), 0);
    end
    sweep_len("sweep_len");

    // reset in the middle of a sweep
    clr_req = 1'b1; cycle(); idle();
    cycle(); cycle(); cycle();
    do_reset();
    sweep_len("sweep_after_reset");

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      idle();
      for (int i = 0; i < NW; i++) if ($urandom_range(0, 1) != 0) wr(i, $urandom_range(0, 3));
      for (int p = 0; p < NR; p++) if ($urandom_range(0, 2) != 0) rd(p, $urandom_range(0, DEPTH - 1));
      clr_req = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
